pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
Multi-channel programmable pulse/clock generator, successor of the single-shot threshold counter.
- Each of NCH independent channels produces either a one-shot pulse of programmable length or a periodic waveform with programmable high time and period.
- A shared tick enable prescales all channels.
- Sits between control registers and downstream clock/strobe consumers. Runs entirely in one clock domain; consumers in other domains resynchronise out themselves.

Parameters:
NCH, 4, number of independent channels
CNT_W, 16, width of high-time/period values and internal phase counters

Ports:
clk  input  1  sole clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tick  input  1  phase advance enable shared by all channels; 1 = advance this cycle
start  input  NCH  per-channel start/restart request, sampled each cycle
stop  input  NCH  per-channel stop request
mode  input  NCH  0 = one-shot, 1 = periodic; latched on start
high_cnt  input  NCH*CNT_W  channel i high time in ticks at [i*CNT_W +: CNT_W]; latched on start
period  input  NCH*CNT_W  channel i period in ticks, same packing; latched on start, periodic only
out  output  NCH  generated waveform, registered
busy  output  NCH  channel running, registered
done  output  NCH  one-cycle completion pulse, registered

Behaviour:
- Reset (reset=1 at a clk edge): out, busy and done all 0 on the following cycle. All channels go to IDLE; phase counters and latched values are cleared. Reset overrides every other input, including mid-run.
- Channel FSM has two states: IDLE and RUN. Per-channel latched values are H, P and M. Pe = max(P,1). Phase counter c is CNT_W bits.
- Start accepted (start[i]=1, stop[i]=0) in either state:
  - Latch H, P and M.
  - Set c <= 0, out <= (H != 0), busy <= 1, state <= RUN.
  - Acceptance does not depend on tick. Restart while RUN discards the old run with no done pulse.
- stop[i]=1 while RUN: next cycle out=0, busy=0, done=1, state=IDLE. stop wins over a simultaneous start. stop in IDLE is ignored and gives no done.
- RUN with tick=1:
  - Next c = (c == Pe-1 && M) ? 0 : c+1.
  - out <= (next c < H).
  - With tick held at 1, out is high for exactly H cycles after the accept edge.
- RUN with tick=0: c and out hold.
- One-shot (M=0):
  - When next c == H on a tick cycle, the channel goes to IDLE. In that same cycle out=0, busy=0 and done=1.
  - H=0: the start edge itself yields out=0, busy=0, done=1 (zero-length shot).
  - P is ignored.
- Periodic (M=1):
  - out is high for H ticks, then low for Pe-H ticks, repeating until stop or restart. done is never asserted.
  - H >= Pe: out stays constant 1.
  - H = 0: out stays constant 0.
  - Wrap-around of c is only via Pe-1 -> 0, never through 2^CNT_W.
- done is always a single-cycle pulse. No channel affects another; simultaneous events on different channels are fully independent.
- Arithmetic is unsigned CNT_W bits with no overflow path. A one-shot with H = 2^CNT_W-1 completes normally.

Test Plan:
- Reset then idle: hold reset 3 cycles -> out=busy=done=0. Pulse stop[0] in IDLE -> no done.
- One-shot ch0, H=5, tick=1: start at cycle 0 -> out[0]=1 on cycles 1-5. At cycle 6, out=0, busy=0 and done=1 for exactly 1 cycle.
- Periodic ch1, H=2, P=5, tick=1 -> out[1] repeats 1,1,0,0,0 for 4 periods. stop -> next cycle out=0, busy=0, done=1.
- Tick prescale: ch2 one-shot H=3, tick=1 every 4th cycle -> out[2] high 12 cycles ±alignment, and c frozen across tick=0 cycles. Bench checks the exact count from its model.
- Corner values:
  - H=0 one-shot -> done on the cycle after start, out never 1.
  - Periodic H=7, P=4 -> out constant 1.
  - Periodic P=0, H=1 -> out constant 1.
  - Start+stop in the same cycle while RUN -> channel stops and gives done.
- Restart/reset mid-run: restart ch3 at c=3 of H=10 -> out continues high for 10 more cycles with no done. Assert reset mid-run -> all outputs 0 the next cycle, with no done.

Source files
------------

// File: rtl/pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// pulse_gen_multi
//   Multi-channel programmable pulse / clock generator. Each of NCH channels
//   independently produces either a one-shot pulse of programmable length or
//   a periodic waveform with programmable high time and period. A shared
//   tick enable prescales the phase counters of all channels.
//
// Ports:
//   clk_i       sole clock, everything on the rising edge
//   reset_i     synchronous active-high reset, overrides every other input
//   tick_i      phase advance enable shared by all channels
//   start_i     per-channel start/restart request
//   stop_i      per-channel stop request (wins over a simultaneous start)
//   mode_i      per-channel mode, 0 = one-shot, 1 = periodic (latched on start)
//   high_cnt_i  channel i high time at [i*CNT_W +: CNT_W] (latched on start)
//   period_i    channel i period, same packing (latched on start)
//   out_o       generated waveform, registered
//   busy_o      channel running, registered
//   done_o      single-cycle completion pulse, registered
// ---------------------------------------------------------------------------
module pulse_gen_multi #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic [NCH-1:0]       start_i,
  input  logic [NCH-1:0]       stop_i,
  input  logic [NCH-1:0]       mode_i,
  input  logic [NCH*CNT_W-1:0] high_cnt_i,
  input  logic [NCH*CNT_W-1:0] period_i,
  output logic [NCH-1:0]       out_o,
  output logic [NCH-1:0]       busy_o,
  output logic [NCH-1:0]       done_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic             m_q, m_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] h_new;
    logic [CNT_W-1:0] pe_m1;
    logic [CNT_W-1:0] c_tick;
    logic             accept;

    // Next-state and output logic for one channel
    always_comb begin
      state_d = state_q;
      c_d     = c_q;
      h_d     = h_q;
      p_d     = p_q;
      m_d     = m_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      h_new  = high_cnt_i[gi*CNT_W +: CNT_W];
      accept = start_i[gi] & ~stop_i[gi];

      // Pe-1 with P=0 treated as P=1, so the subtraction never underflows
      if (p_q == CNT_ZERO) begin
        pe_m1 = CNT_ZERO;
      end else begin
        pe_m1 = p_q - CNT_ONE;
      end

      // Periodic channels wrap at Pe-1; one-shots never reach 2^CNT_W-1 + 1
      // because they terminate when the counter reaches H.
      if (m_q && (c_q == pe_m1)) begin
        c_tick = CNT_ZERO;
      end else begin
        c_tick = c_q + CNT_ONE;
      end

      if ((state_q == ST_RUN) && stop_i[gi]) begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else if (accept) begin
        h_d = h_new;
        p_d = period_i[gi*CNT_W +: CNT_W];
        m_d = mode_i[gi];
        c_d = CNT_ZERO;
        // A zero-length one-shot completes on its own start edge
        if (!mode_i[gi] && (h_new == CNT_ZERO)) begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          out_d   = (h_new != CNT_ZERO);
          busy_d  = 1'b1;
        end
      end else if ((state_q == ST_RUN) && tick_i) begin
        c_d = c_tick;
        if (!m_q && (c_tick == h_q)) begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          out_d = (c_tick < h_q);
        end
      end else begin
        state_d = state_q;
      end
    end

    // Channel state register with synchronous reset
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= ST_IDLE;
        c_q     <= CNT_ZERO;
        h_q     <= CNT_ZERO;
        p_q     <= CNT_ZERO;
        m_q     <= 1'b0;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        c_q     <= c_d;
        h_q     <= h_d;
        p_q     <= p_d;
        m_q     <= m_d;
        out_q   <= out_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
      end
    end

    assign out_o[gi]  = out_q;
    assign busy_o[gi] = busy_q;
    assign done_o[gi] = done_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen_multi
//   Self-checking bench for pulse_gen_multi. A behavioural reference model
//   predicts out/busy/done for every clock; predictions are queued when the
//   stimulus is applied and compared once the DUT has registered the edge.
//   Directed checks on pulse lengths and patterns complement the model.
// ---------------------------------------------------------------------------
module tb_pulse_gen_multi;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tick;
  logic [NCH-1:0]       start;
  logic [NCH-1:0]       stop;
  logic [NCH-1:0]       mode;
  logic [NCH*CNT_W-1:0] high_cnt;
  logic [NCH*CNT_W-1:0] period;
  logic [NCH-1:0]       out_s;
  logic [NCH-1:0]       busy_s;
  logic [NCH-1:0]       done_s;

  always #5 clk = ~clk;

  pulse_gen_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .tick_i     (tick),
    .start_i    (start),
    .stop_i     (stop),
    .mode_i     (mode),
    .high_cnt_i (high_cnt),
    .period_i   (period),
    .out_o      (out_s),
    .busy_o     (busy_s),
    .done_o     (done_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [NCH-1:0] o;
    logic [NCH-1:0] b;
    logic [NCH-1:0] d;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  int             m_run [NCH];
  int             m_c   [NCH];
  int             m_h   [NCH];
  int             m_p   [NCH];
  int             m_m   [NCH];
  logic [NCH-1:0] m_out;
  logic [NCH-1:0] m_busy;
  logic [NCH-1:0] m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_update();
    int pe;
    for (int i = 0; i < NCH; i++) begin
      m_done[i] = 1'b0;
      if (reset) begin
        m_run[i] = 0; m_c[i] = 0; m_h[i] = 0; m_p[i] = 0; m_m[i] = 0;
        m_out[i] = 1'b0; m_busy[i] = 1'b0;
      end else if ((m_run[i] != 0) && stop[i]) begin
        m_run[i] = 0; m_out[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
      end else if (start[i] && !stop[i]) begin
        m_h[i] = int'(high_cnt[i*CNT_W +: CNT_W]);
        m_p[i] = int'(period[i*CNT_W +: CNT_W]);
        m_m[i] = int'(mode[i]);
        m_c[i] = 0;
        if (m_m[i] == 0 && m_h[i] == 0) begin
          m_run[i] = 0; m_out[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
        end else begin
          m_run[i] = 1; m_out[i] = (m_h[i] != 0); m_busy[i] = 1'b1;
        end
      end else if ((m_run[i] != 0) && tick) begin
        if (m_m[i] != 0) begin
          pe = (m_p[i] == 0) ? 1 : m_p[i];
          m_c[i] = (m_c[i] + 1) % pe;
          m_out[i] = (m_c[i] < m_h[i]);
        end else begin
          m_c[i] = m_c[i] + 1;
          if (m_c[i] == m_h[i]) begin
            m_run[i] = 0; m_out[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
          end else begin
            m_out[i] = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: predict, push, clock, pop and compare
  task automatic step();
    exp_t e;
    model_update();
    e = {m_out, m_busy, m_done};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("out",  32'(out_s),  32'(e.o));
      chk("busy", 32'(busy_s), 32'(e.b));
      chk("done", 32'(done_s), 32'(e.d));
    end
  endtask

  task automatic set_ch(input int ch, input logic md, input int h, input int p);
    mode[ch] = md;
    high_cnt[ch*CNT_W +: CNT_W] = CNT_W'(h);
    period[ch*CNT_W +: CNT_W]   = CNT_W'(p);
  endtask

  initial begin
    int         hi_cnt;
    int         dn_cnt;
    logic [19:0] pat;

    reset = 1'b1; tick = 1'b1; start = '0; stop = '0; mode = '0;
    high_cnt = '0; period = '0;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_c[i] = 0; m_h[i] = 0; m_p[i] = 0; m_m[i] = 0;
    end
    m_out = '0; m_busy = '0; m_done = '0;

    // reset, then stop in IDLE gives nothing
    repeat (3) step();
    chk("reset_out", 32'(out_s), 32'd0);
    chk("reset_busy", 32'(busy_s), 32'd0);
    reset = 1'b0;
    step();
    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    chk("idle_stop_done", 32'(done_s[0]), 32'd0);
    step();

    // one-shot ch0, H=5
    set_ch(0, 1'b0, 5, 0);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    hi_cnt = int'(out_s[0]); dn_cnt = int'(done_s[0]);
    for (int k = 0; k < 8; k++) begin
      step();
      hi_cnt += int'(out_s[0]); dn_cnt += int'(done_s[0]);
    end
    chk("oneshot_high_len", 32'(hi_cnt), 32'd5);
    chk("oneshot_done_cnt", 32'(dn_cnt), 32'd1);

    // periodic ch1, H=2 P=5 for 4 periods
    set_ch(1, 1'b1, 2, 5);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    pat = {19'd0, out_s[1]};
    for (int k = 0; k < 19; k++) begin
      step();
      pat = {pat[18:0], out_s[1]};
    end
    chk("periodic_pattern", 32'(pat), 32'h000C6318);
    stop[1] = 1'b1; step(); stop[1] = 1'b0;
    chk("periodic_stop_done", 32'(done_s[1]), 32'd1);
    step();

    // tick prescale ch2, H=3, tick every 4th cycle
    set_ch(2, 1'b0, 3, 0);
    tick = 1'b0;
    start[2] = 1'b1; step(); start[2] = 1'b0;
    hi_cnt = int'(out_s[2]);
    for (int k = 1; k <= 20; k++) begin
      tick = (k % 4 == 3);
      step();
      hi_cnt += int'(out_s[2]);
    end
    chk("prescale_high_len", 32'(hi_cnt), 32'd11);
    tick = 1'b1;
    step();

    // H=0 one-shot
    set_ch(0, 1'b0, 0, 0);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("zero_shot_done", 32'(done_s[0]), 32'd1);
    chk("zero_shot_out", 32'(out_s[0]), 32'd0);
    step(); step();

    // periodic H=7 P=4 and H=1 P=0: constant high
    set_ch(1, 1'b1, 7, 4);
    set_ch(2, 1'b1, 1, 0);
    start[1] = 1'b1; start[2] = 1'b1; step(); start = '0;
    hi_cnt = int'(out_s[1]); dn_cnt = int'(out_s[2]);
    for (int k = 0; k < 10; k++) begin
      step();
      hi_cnt += int'(out_s[1]); dn_cnt += int'(out_s[2]);
    end
    chk("h_ge_p_const", 32'(hi_cnt), 32'd11);
    chk("p0_const", 32'(dn_cnt), 32'd11);
    stop[1] = 1'b1; stop[2] = 1'b1; step(); stop = '0;
    step();

    // start+stop together while RUN
    set_ch(3, 1'b1, 2, 3);
    start[3] = 1'b1; step(); start[3] = 1'b0;
    step(); step();
    start[3] = 1'b1; stop[3] = 1'b1; step(); start[3] = 1'b0; stop[3] = 1'b0;
    chk("start_stop_done", 32'(done_s[3]), 32'd1);
    chk("start_stop_busy", 32'(busy_s[3]), 32'd0);
    step();

    // restart ch3 at c=3 of H=10
    set_ch(3, 1'b0, 10, 0);
    start[3] = 1'b1; step(); start[3] = 1'b0;
    step(); step(); step();
    start[3] = 1'b1; step(); start[3] = 1'b0;
    chk("restart_no_done", 32'(done_s[3]), 32'd0);
    hi_cnt = int'(out_s[3]); dn_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      hi_cnt += int'(out_s[3]); dn_cnt += int'(done_s[3]);
    end
    chk("restart_high_len", 32'(hi_cnt), 32'd10);
    chk("restart_done_cnt", 32'(dn_cnt), 32'd1);

    // reset mid-run
    set_ch(0, 1'b0, 20, 0);
    set_ch(1, 1'b1, 2, 5);
    start[0] = 1'b1; start[1] = 1'b1; step(); start = '0;
    step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrun_reset_out", 32'(out_s), 32'd0);
    chk("midrun_reset_done", 32'(done_s), 32'd0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
